// File: rtl/shift_frame_collector.sv
// Counts same-direction shifts of a WIDTH-bit shift register, captures each completed
// frame one cycle later, and queues {direction, data} in a first-word-fall-through FIFO.
module shift_frame_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       direction,
  input  logic [WIDTH-1:0]           sr_q,
  input  logic                       clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_dir,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
);

  localparam int SCW = $clog2(WIDTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = $clog2(DEPTH) + 1;

  logic [SCW-1:0]   sc_q, sc_d, sc_inc;
  logic             cur_dir_q, cur_dir_d;
  logic             commit_pend_q, commit_pend_d;
  logic             commit_dir_q, commit_dir_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] last_data_q, last_data_d;
  logic             last_dir_q, last_dir_d;
  logic [WIDTH:0]   mem [DEPTH];

  logic             frame_done;
  logic             pop, push, drop;
  logic [WIDTH:0]   head;

  assign head      = mem[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign ovf       = ovf_q;
  // When empty the outputs keep showing the most recently popped entry.
  assign out_data  = out_valid ? head[WIDTH-1:0] : last_data_q;
  assign out_dir   = out_valid ? head[WIDTH]     : last_dir_q;

  assign pop  = out_valid && out_ready;
  assign push = commit_pend_q && (!full || pop);
  assign drop = commit_pend_q && full && !pop;

  always_comb begin
    sc_inc        = ((sc_q == '0) || (direction == cur_dir_q)) ? sc_q + SCW'(1) : SCW'(1);
    frame_done    = en && (sc_inc == SCW'(WIDTH));
    sc_d          = sc_q;
    cur_dir_d     = cur_dir_q;
    commit_pend_d = frame_done;
    commit_dir_d  = commit_dir_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    ovf_d         = ovf_q | drop;
    last_data_d   = last_data_q;
    last_dir_d    = last_dir_q;

    if (en) begin
      cur_dir_d = direction;
      sc_d      = frame_done ? '0 : sc_inc;
      if (frame_done) commit_dir_d = direction;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      last_data_d = head[WIDTH-1:0];
      last_dir_d  = head[WIDTH];
    end
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // A flush wins over every other update in the same cycle.
    if (clr) begin
      sc_d          = '0;
      cur_dir_d     = 1'b0;
      commit_pend_d = 1'b0;
      commit_dir_d  = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      ovf_d         = 1'b0;
      last_data_d   = '0;
      last_dir_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q          <= '0;
      cur_dir_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      commit_dir_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      ovf_q         <= 1'b0;
      last_data_q   <= '0;
      last_dir_q    <= 1'b0;
    end else begin
      sc_q          <= sc_d;
      cur_dir_q     <= cur_dir_d;
      commit_pend_q <= commit_pend_d;
      commit_dir_q  <= commit_dir_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      ovf_q         <= ovf_d;
      last_data_q   <= last_data_d;
      last_dir_q    <= last_dir_d;
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= {commit_dir_q, sr_q};
  end

endmodule

// File: tb/tb_shift_frame_collector.sv
// Directed bench for shift_frame_collector: models the upstream shift register timing
// (sr_q changes just after each shifting edge) and checks FIFO contents and flags.
module tb_shift_frame_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       direction = 1'b0;
  logic [3:0] sr_q = 4'h0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_dir;
  logic       full;
  logic [2:0] level;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  shift_frame_collector #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .direction(direction), .sr_q(sr_q), .clr(clr),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_dir(out_dir),
    .full(full), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic do_shift(input logic d, input logic [3:0] v);
    @(negedge clk);
    en = 1'b1;
    direction = d;
    @(posedge clk);
    #1;
    sr_q = v;
    en = 1'b0;
  endtask

  task automatic do_frame(input logic d, input logic [3:0] v, input logic pop_at_commit);
    for (int i = 0; i < 4; i++) do_shift(d, (i == 3) ? v : 4'h0);
    out_ready = pop_at_commit;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, level, ovf, out_data, out_dir, full} !== 10'b0) begin
      $display("FAIL reset_hold got valid=%0b level=%0d ovf=%0b data=%h expected all 0",
               out_valid, level, ovf, out_data);
      failures++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, level, ovf, out_data} !== 9'b0) begin
        $display("FAIL idle_%0d got valid=%0b level=%0d ovf=%0b data=%h expected all 0",
                 i, out_valid, level, ovf, out_data);
        failures++;
      end
    end
  endtask

  task automatic test_single_frame();
    do_shift(1'b0, 4'b0001);
    do_shift(1'b0, 4'b0011);
    do_shift(1'b0, 4'b0111);
    do_shift(1'b0, 4'b1111);
    checks++;
    if (level !== 3'd0) begin
      $display("FAIL commit_latency got level=%0d expected 0", level);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_dir, level} !== {1'b1, 4'b1111, 1'b0, 3'd1}) begin
      $display("FAIL single_frame got valid=%0b data=%b dir=%0b level=%0d expected 1 1111 0 1",
               out_valid, out_data, out_dir, level);
      failures++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, level, out_data} !== {1'b0, 3'd0, 4'b1111}) begin
      $display("FAIL single_pop got valid=%0b level=%0d data=%b expected 0 0 1111(held)",
               out_valid, level, out_data);
      failures++;
    end
  endtask

  task automatic test_direction_abort();
    do_shift(1'b0, 4'h3);
    do_shift(1'b0, 4'h6);
    for (int i = 0; i < 4; i++) do_shift(1'b1, (i == 3) ? 4'b1010 : 4'h5);
    @(posedge clk);
    #1;
    checks++;
    if ({level, out_data, out_dir} !== {3'd1, 4'b1010, 1'b1}) begin
      $display("FAIL dir_abort got level=%0d data=%b dir=%0b expected 1 1010 1",
               level, out_data, out_dir);
      failures++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL dir_abort_drain got valid=%0b expected 0", out_valid);
      failures++;
    end
  endtask

  task automatic test_fill_overflow();
    for (int f = 1; f <= 4; f++) do_frame(1'b0, 4'(f), 1'b0);
    checks++;
    if ({full, level, ovf} !== {1'b1, 3'd4, 1'b0}) begin
      $display("FAIL fill got full=%0b level=%0d ovf=%0b expected 1 4 0", full, level, ovf);
      failures++;
    end
    do_frame(1'b0, 4'd5, 1'b0);
    checks++;
    if ({full, level, ovf} !== {1'b1, 3'd4, 1'b1}) begin
      $display("FAIL overflow got full=%0b level=%0d ovf=%0b expected 1 4 1", full, level, ovf);
      failures++;
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data} !== {1'b1, 4'(i)}) begin
        $display("FAIL drain_%0d got valid=%0b data=%0d expected 1 %0d", i, out_valid, out_data, i);
        failures++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    checks++;
    if ({out_valid, ovf} !== 2'b01) begin
      $display("FAIL drained got valid=%0b ovf=%0b expected 0 1", out_valid, ovf);
      failures++;
    end
  endtask

  task automatic test_clear();
    for (int f = 0; f < 3; f++) do_frame(1'b1, 4'hA + 4'(f), 1'b0);
    do_shift(1'b1, 4'h1);
    do_shift(1'b1, 4'h2);
    checks++;
    if ({level, ovf} !== {3'd3, 1'b1}) begin
      $display("FAIL pre_clr got level=%0d ovf=%0b expected 3 1", level, ovf);
      failures++;
    end
    do_clr();
    checks++;
    if ({level, out_valid, ovf} !== 5'b0) begin
      $display("FAIL clr got level=%0d valid=%0b ovf=%0b expected 0 0 0", level, out_valid, ovf);
      failures++;
    end
    do_shift(1'b1, 4'h0);
    do_shift(1'b1, 4'h9);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (level !== 3'd0) begin
      $display("FAIL clr_sc got level=%0d expected 0 after 2 shifts", level);
      failures++;
    end
    do_shift(1'b1, 4'h0);
    do_shift(1'b1, 4'h9);
    @(posedge clk);
    #1;
    checks++;
    if ({level, out_data, out_dir} !== {3'd1, 4'h9, 1'b1}) begin
      $display("FAIL clr_refill got level=%0d data=%h dir=%0b expected 1 9 1", level, out_data, out_dir);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q [4];
    do_clr();
    for (int f = 0; f < 4; f++) do_frame(1'b1, 4'h6 + 4'(f), 1'b0);
    do_frame(1'b0, 4'hC, 1'b1);
    checks++;
    if ({level, full, ovf, out_data} !== {3'd4, 1'b1, 1'b0, 4'h7}) begin
      $display("FAIL full_pop got level=%0d full=%0b ovf=%0b head=%h expected 4 1 0 7",
               level, full, ovf, out_data);
      failures++;
    end
    exp_q[0] = 4'h7; exp_q[1] = 4'h8; exp_q[2] = 4'h9; exp_q[3] = 4'hC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_dir} !== {1'b1, exp_q[i], (i == 3) ? 1'b0 : 1'b1}) begin
        $display("FAIL fp_drain_%0d got valid=%0b data=%h dir=%0b expected 1 %h %0b",
                 i, out_valid, out_data, out_dir, exp_q[i], (i == 3) ? 1'b0 : 1'b1);
        failures++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    do_frame(1'b1, 4'h5, 1'b0);
    for (int i = 0; i < 4; i++) do_shift(1'b1, (i == 3) ? 4'h6 : 4'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, level, out_data, out_dir, full, ovf} !== 10'b0) begin
      $display("FAIL async_rst got valid=%0b level=%0d data=%h dir=%0b expected all 0",
               out_valid, level, out_data, out_dir);
      failures++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, level} !== 4'b0) begin
      $display("FAIL async_rst_nopush got valid=%0b level=%0d expected 0 0", out_valid, level);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_direction_abort();
    test_fill_overflow();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
